yuv444_to_422: RTL and testbench

- Downstream neighbour of the RGB-to-YUV converter. Consumes its 4:4:4 Y/U/V pixel stream and produces a 4:2:2 stream: one luma sample and one chroma sample per beat.
- Chroma alternates between U and V. Each chroma sample is the rounded average of the two pixels in a horizontal pair.
- Keeps dvi/dtype/meta_data timing aligned with the pixels so later packers and the frame writer see a consistent stream.

---
 rtl/yuv444_to_422.sv | 143 ++++++++++++++
 tb/tb_yuv444_to_422.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/yuv444_to_422.sv
// 4:4:4 to 4:2:2 chroma downsampler: one luma plus alternating U/V per beat,
// chroma averaged over horizontal pixel pairs, fixed two-cycle latency.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

module yuv444_to_422 #(
    parameter int PIXEL_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    enable,
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic [15:0]             meta_datai,
    input  logic [PIXEL_WIDTH-1:0]  y,
    input  logic [PIXEL_WIDTH-1:0]  u,
    input  logic [PIXEL_WIDTH-1:0]  v,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic [15:0]             meta_datao,
    output logic [PIXEL_WIDTH-1:0]  yo,
    output logic [PIXEL_WIDTH-1:0]  co,
    output logic                    c_is_v
);

    localparam int W = PIXEL_WIDTH;

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } phase_t;

    phase_t phase;
    phase_t phase_nxt;

    logic                    s1_dv;
    logic                    s1_odd;
    logic                    s1_en;
    logic [`DTYPE_WIDTH-1:0] s1_dtype;
    logic [15:0]             s1_meta;
    logic [W-1:0]            s1_y;
    logic [W-1:0]            s1_u;
    logic [W-1:0]            s1_v;

    logic [W-1:0]            v_hold;
    logic                    en_hold;

    logic [W:0]              u_sum;
    logic [W:0]              v_sum;
    logic                    pair_start;
    logic                    pair_end;
    logic [W-1:0]            yo_nxt;
    logic [W-1:0]            co_nxt;
    logic                    cv_nxt;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            phase <= EVEN;
        end else begin
            phase <= phase_nxt;
        end
    end

    always_comb begin
        phase_nxt = EVEN;
        if (dvi) begin
            phase_nxt = (phase == EVEN) ? ODD : EVEN;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            s1_dv    <= 1'b0;
            s1_odd   <= 1'b0;
            s1_en    <= 1'b0;
            s1_dtype <= '0;
            s1_meta  <= '0;
            s1_y     <= '0;
            s1_u     <= '0;
            s1_v     <= '0;
        end else begin
            s1_dv    <= dvi;
            s1_odd   <= dvi & (phase == ODD);
            s1_en    <= enable;
            s1_dtype <= dtypei;
            s1_meta  <= meta_datai;
            s1_y     <= y;
            s1_u     <= u;
            s1_v     <= v;
        end
    end

    // Stage 1 holds the even pixel while its odd partner is on the inputs.
    assign u_sum = {1'b0, s1_u} + {1'b0, u} + (W+1)'(1);
    assign v_sum = {1'b0, s1_v} + {1'b0, v} + (W+1)'(1);

    assign pair_start = s1_dv & ~s1_odd;
    assign pair_end   = s1_dv & s1_odd;

    always_comb begin
        yo_nxt = '0;
        co_nxt = '0;
        cv_nxt = 1'b0;
        if (pair_start) begin
            yo_nxt = s1_y;
            co_nxt = (s1_en && dvi) ? u_sum[W:1] : s1_u;
        end else if (pair_end) begin
            yo_nxt = s1_y;
            co_nxt = en_hold ? v_hold : s1_v;
            cv_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            v_hold  <= '0;
            en_hold <= 1'b0;
        end else if (pair_start) begin
            v_hold  <= v_sum[W:1];
            en_hold <= s1_en;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            dvo        <= 1'b0;
            dtypeo     <= '0;
            meta_datao <= '0;
            yo         <= '0;
            co         <= '0;
            c_is_v     <= 1'b0;
        end else begin
            dvo        <= s1_dv;
            dtypeo     <= s1_dtype;
            meta_datao <= s1_meta;
            yo         <= yo_nxt;
            co         <= co_nxt;
            c_is_v     <= cv_nxt;
        end
    end

endmodule

// File: tb/tb_yuv444_to_422.sv
// Scoreboard bench for yuv444_to_422: line-level reference model feeds a
// queue of expected beats that a negedge monitor compares against the DUT.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

module tb_yuv444_to_422;

    localparam int W  = 10;
    localparam int DT = `DTYPE_WIDTH;
    localparam int MX = 512;

    logic          clk;
    logic          resetb;
    logic          enable;
    logic          dvi;
    logic [DT-1:0] dtypei;
    logic [15:0]   meta_datai;
    logic [W-1:0]  y;
    logic [W-1:0]  u;
    logic [W-1:0]  v;
    logic          dvo;
    logic [DT-1:0] dtypeo;
    logic [15:0]   meta_datao;
    logic [W-1:0]  yo;
    logic [W-1:0]  co;
    logic          c_is_v;

    yuv444_to_422 #(.PIXEL_WIDTH(W)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .enable     (enable),
        .dvi        (dvi),
        .dtypei     (dtypei),
        .meta_datai (meta_datai),
        .y          (y),
        .u          (u),
        .v          (v),
        .dvo        (dvo),
        .dtypeo     (dtypeo),
        .meta_datao (meta_datao),
        .yo         (yo),
        .co         (co),
        .c_is_v     (c_is_v)
    );

    typedef struct packed {
        logic          dv;
        logic [DT-1:0] dt;
        logic [15:0]   md;
        logic [W-1:0]  y;
        logic [W-1:0]  c;
        logic          cv;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   errors = 0;

    int   n;
    bit   st_dv[MX];
    bit   st_en[MX];
    int   st_y[MX];
    int   st_u[MX];
    int   st_v[MX];
    int   st_dt[MX];
    int   st_md[MX];
    rec_t ex[MX];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        rec_t r;
        if (!resetb) begin
            checks++;
            if ({dvo, dtypeo, meta_datao, yo, co, c_is_v} != '0) begin
                errors++;
                $display("FAIL reset_outputs dvo=%0d y=%0d c=%0d cv=%0d dt=%0d md=%0d expected all 0",
                         dvo, yo, co, c_is_v, dtypeo, meta_datao);
            end
        end else if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow no expected beat at t=%0t", $time);
        end else begin
            r = q.pop_front();
            checks++;
            if ({dvo, dtypeo, meta_datao, yo, co, c_is_v} != r) begin
                errors++;
                $display("FAIL beat t=%0t got dv=%0d dt=%0d md=%0d y=%0d c=%0d cv=%0d exp dv=%0d dt=%0d md=%0d y=%0d c=%0d cv=%0d",
                         $time, dvo, dtypeo, meta_datao, yo, co, c_is_v,
                         r.dv, r.dt, r.md, r.y, r.c, r.cv);
            end
        end
    end

    task automatic clear_stim();
        n = 0;
    endtask

    task automatic add(input bit dv, input int py, input int pu, input int pv,
                       input bit en, input bit rnd_side);
        st_dv[n] = dv;
        st_y[n]  = py;
        st_u[n]  = pu;
        st_v[n]  = pv;
        st_en[n] = en;
        st_dt[n] = rnd_side ? int'($urandom_range(0, (1 << DT) - 1)) : 0;
        st_md[n] = rnd_side ? int'($urandom_range(0, 65535)) : 0;
        n++;
    endtask

    task automatic add_gap(input int cnt, input bit rnd_side);
        for (int i = 0; i < cnt; i++) begin
            add(1'b0, 0, 0, 0, 1'($urandom_range(0, 1)), rnd_side);
        end
    endtask

    // Reference: split stimulus into lines, pair pixels from line start.
    task automatic build_exp();
        int k;
        int s;
        int len;
        int e;
        bit en;
        k = 0;
        while (k < n) begin
            if (!st_dv[k]) begin
                ex[k]    = '0;
                ex[k].dt = DT'(st_dt[k]);
                ex[k].md = 16'(st_md[k]);
                k++;
            end else begin
                s   = k;
                len = 0;
                while (k < n && st_dv[k]) begin
                    k++;
                    len++;
                end
                for (int j = 0; j < len; j++) begin
                    e  = s + (j / 2) * 2;
                    en = st_en[e];
                    ex[s+j]    = '0;
                    ex[s+j].dv = 1'b1;
                    ex[s+j].dt = DT'(st_dt[s+j]);
                    ex[s+j].md = 16'(st_md[s+j]);
                    ex[s+j].y  = W'(st_y[s+j]);
                    if (j % 2 == 0) begin
                        if (j + 1 < len && en)
                            ex[s+j].c = W'((st_u[e] + st_u[e+1] + 1) / 2);
                        else
                            ex[s+j].c = W'(st_u[e]);
                        ex[s+j].cv = 1'b0;
                    end else begin
                        if (en)
                            ex[s+j].c = W'((st_v[e] + st_v[e+1] + 1) / 2);
                        else
                            ex[s+j].c = W'(st_v[e+1]);
                        ex[s+j].cv = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic idle_inputs();
        dvi        = 1'b0;
        enable     = 1'b0;
        dtypei     = '0;
        meta_datai = '0;
        y          = '0;
        u          = '0;
        v          = '0;
    endtask

    task automatic do_reset(input int cyc);
        @(posedge clk);
        #1;
        resetb = 1'b0;
        idle_inputs();
        q.delete();
        #1;
        checks++;
        if ({dvo, dtypeo, meta_datao, yo, co, c_is_v} != '0) begin
            errors++;
            $display("FAIL async_reset dvo=%0d y=%0d c=%0d cv=%0d expected all 0",
                     dvo, yo, co, c_is_v);
        end
        repeat (cyc) @(posedge clk);
        #1;
        resetb = 1'b1;
        for (int i = 0; i < 3; i++) q.push_back('0);
    endtask

    task automatic drive(input int upto);
        build_exp();
        for (int k = 0; k < upto; k++) begin
            @(posedge clk);
            #1;
            dvi        = st_dv[k];
            enable     = st_en[k];
            dtypei     = DT'(st_dt[k]);
            meta_datai = 16'(st_md[k]);
            y          = W'(st_y[k]);
            u          = W'(st_u[k]);
            v          = W'(st_v[k]);
            q.push_back(ex[k]);
        end
    endtask

    task automatic gen_random(input int lines);
        int len;
        int pv[3];
        clear_stim();
        add_gap(1, 1'b1);
        for (int l = 0; l < lines; l++) begin
            len = $urandom_range(1, 9);
            for (int p = 0; p < len; p++) begin
                for (int c = 0; c < 3; c++) begin
                    pv[c] = ($urandom_range(0, 5) == 0) ? 1023
                                                        : int'($urandom_range(0, 1023));
                end
                add(1'b1, pv[0], pv[1], pv[2], 1'($urandom_range(0, 1)), 1'b1);
            end
            add_gap($urandom_range(1, 3), 1'b1);
        end
        add_gap(2, 1'b1);
    endtask

    initial begin
        resetb = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);

        do_reset(2);
        clear_stim();
        add_gap(10, 1'b0);
        drive(n);

        clear_stim();
        add(1'b1, 100, 10, 20, 1'b1, 1'b1);
        add(1'b1, 101, 11, 23, 1'b1, 1'b1);
        add(1'b1, 200, 1023, 0, 1'b1, 1'b1);
        add(1'b1, 201, 1023, 1, 1'b1, 1'b1);
        add_gap(3, 1'b1);
        drive(n);

        clear_stim();
        add(1'b1, 100, 10, 20, 1'b0, 1'b1);
        add(1'b1, 101, 11, 23, 1'b0, 1'b1);
        add(1'b1, 200, 1023, 0, 1'b0, 1'b1);
        add(1'b1, 201, 1023, 1, 1'b0, 1'b1);
        add_gap(3, 1'b1);
        drive(n);

        clear_stim();
        add(1'b1, 5, 8, 8, 1'b1, 1'b1);
        add(1'b1, 6, 9, 9, 1'b1, 1'b1);
        add(1'b1, 7, 40, 50, 1'b1, 1'b1);
        add_gap(1, 1'b1);
        add(1'b1, 9, 2, 3, 1'b1, 1'b1);
        add_gap(3, 1'b1);
        drive(n);

        clear_stim();
        add(1'b1, 1, 100, 200, 1'b1, 1'b1);
        add(1'b1, 2, 301, 7, 1'b0, 1'b1);
        add(1'b1, 3, 500, 600, 1'b0, 1'b1);
        add(1'b1, 4, 55, 66, 1'b1, 1'b1);
        add(1'b1, 5, 77, 88, 1'b1, 1'b1);
        add(1'b1, 6, 99, 11, 1'b1, 1'b1);
        add_gap(3, 1'b1);
        drive(n);

        clear_stim();
        add(1'b1, 10, 20, 30, 1'b1, 1'b1);
        add(1'b1, 11, 21, 31, 1'b1, 1'b1);
        add(1'b1, 12, 500, 700, 1'b1, 1'b1);
        add(1'b1, 13, 900, 100, 1'b1, 1'b1);
        drive(3);
        do_reset(1);

        clear_stim();
        add(1'b1, 40, 3, 4, 1'b1, 1'b1);
        add(1'b1, 41, 6, 9, 1'b1, 1'b1);
        add(1'b1, 42, 1, 2, 1'b0, 1'b1);
        add_gap(3, 1'b1);
        drive(n);

        for (int r = 0; r < 3; r++) begin
            gen_random(25);
            drive(n);
        end

        repeat (2) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
